// File: rtl/traffic_light_ctrl.sv
// Two-road intersection controller with all-red clearance, pedestrian
// early-cut of green and a hold enable. Lamp encoding: RED=001,
// GREEN=010, YELLOW=100.
// Optional build macro FLASH_MODE_EN adds a blinking-yellow flash mode.
//
// state     | meaning
// ----------+-------------------------------------------
// ALLRED_A  | clearance before NS green, both roads red
// NS_GREEN  | NS green, EW red
// NS_YELLOW | NS yellow, EW red
// ALLRED_B  | clearance before EW green, both roads red
// EW_GREEN  | EW green, NS red
// EW_YELLOW | EW yellow, NS red
// FLASH     | both roads blink yellow (FLASH_MODE_EN only)
module traffic_light_ctrl #(
  parameter int GREEN_CYCLES     = 8,
  parameter int YELLOW_CYCLES    = 3,
  parameter int ALLRED_CYCLES    = 2,
  parameter int MIN_GREEN_CYCLES = 3,
  parameter int FLASH_CYCLES     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       ped_req,
  input  logic       flash,
  output logic [2:0] light_ns,
  output logic [2:0] light_ew,
  output logic       ped_walk,
  output logic [2:0] phase
);

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b100;

  localparam int MAX_CYC = (GREEN_CYCLES > YELLOW_CYCLES) ?
                           ((GREEN_CYCLES > ALLRED_CYCLES) ? GREEN_CYCLES : ALLRED_CYCLES) :
                           ((YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES);
`ifdef FLASH_MODE_EN
  // The blink period is counted with the same dwell counter.
  localparam int MAX_DWELL = (2 * FLASH_CYCLES > MAX_CYC) ? 2 * FLASH_CYCLES : MAX_CYC;
`else
  localparam int MAX_DWELL = MAX_CYC;
  localparam int flash_cycles_unused = FLASH_CYCLES;
  logic flash_unused;
  assign flash_unused = flash;
`endif
  localparam int CW = $clog2(MAX_DWELL + 1);

  localparam logic [CW-1:0] G_LAST  = CW'(GREEN_CYCLES - 1);
  localparam logic [CW-1:0] Y_LAST  = CW'(YELLOW_CYCLES - 1);
  localparam logic [CW-1:0] AR_LAST = CW'(ALLRED_CYCLES - 1);
  localparam logic [CW-1:0] MG_LAST = CW'(MIN_GREEN_CYCLES - 1);
`ifdef FLASH_MODE_EN
  localparam logic [CW-1:0] F_HALF  = CW'(FLASH_CYCLES);
  localparam logic [CW-1:0] F_LAST  = CW'(2 * FLASH_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    ALLRED_A  = 3'd0,
    NS_GREEN  = 3'd1,
    NS_YELLOW = 3'd2,
    ALLRED_B  = 3'd3,
    EW_GREEN  = 3'd4,
    EW_YELLOW = 3'd5,
    FLASH     = 3'd6
  } state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          ped_pending, pend_nx;
  logic          walk_nx;
  logic [2:0]    ns_nx, ew_nx;
  logic          done;

  // State, counter, pedestrian latch and registered lamp decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALLRED_A;
      cnt         <= '0;
      ped_pending <= 1'b0;
      ped_walk    <= 1'b0;
      light_ns    <= RED;
      light_ew    <= RED;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      ped_pending <= pend_nx;
      ped_walk    <= walk_nx;
      light_ns    <= ns_nx;
      light_ew    <= ew_nx;
    end
  end

  assign phase = state;

  // Next state, dwell counter, pedestrian handling and lamp decode.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    walk_nx  = ped_walk;
    pend_nx  = ped_pending | ped_req;
    done     = 1'b0;

    case (state)
      ALLRED_A, ALLRED_B:   done = (cnt == AR_LAST);
      NS_GREEN, EW_GREEN:   done = (cnt == G_LAST) || (ped_pending && (cnt >= MG_LAST));
      NS_YELLOW, EW_YELLOW: done = (cnt == Y_LAST);
      default:              done = 1'b0;
    endcase

    if (en) begin
      if (done) begin
        case (state)
          ALLRED_A:  state_nx = NS_GREEN;
          NS_GREEN:  state_nx = NS_YELLOW;
          NS_YELLOW: state_nx = ALLRED_B;
          ALLRED_B:  state_nx = EW_GREEN;
          EW_GREEN:  state_nx = EW_YELLOW;
          default:   state_nx = ALLRED_A;
        endcase
        cnt_nx = '0;
        // The walk window covers exactly the clearance phase; a request
        // arriving on this same edge is kept for the next green.
        if (state_nx == ALLRED_A || state_nx == ALLRED_B) begin
          walk_nx = ped_pending;
          pend_nx = ped_req;
        end else begin
          walk_nx = 1'b0;
        end
      end else begin
        cnt_nx = cnt + 1'b1;
      end
    end

`ifdef FLASH_MODE_EN
    if (state == FLASH) begin
      pend_nx = 1'b0;
      walk_nx = 1'b0;
      cnt_nx  = cnt;
      if (en) begin
        state_nx = ALLRED_A;
        cnt_nx   = '0;
      end
    end
    if (en && flash) begin
      state_nx = FLASH;
      pend_nx  = 1'b0;
      walk_nx  = 1'b0;
      if (state == FLASH) cnt_nx = (cnt == F_LAST) ? '0 : cnt + 1'b1;
      else                cnt_nx = '0;
    end
    if (state == 3'd7) begin
`else
    if (state > EW_YELLOW) begin
`endif
      state_nx = ALLRED_A;
      cnt_nx   = '0;
      walk_nx  = 1'b0;
    end

    case (state_nx)
      NS_GREEN:  begin ns_nx = GREEN;  ew_nx = RED;    end
      NS_YELLOW: begin ns_nx = YELLOW; ew_nx = RED;    end
      EW_GREEN:  begin ns_nx = RED;    ew_nx = GREEN;  end
      EW_YELLOW: begin ns_nx = RED;    ew_nx = YELLOW; end
`ifdef FLASH_MODE_EN
      FLASH: begin
        ns_nx = (cnt_nx < F_HALF) ? YELLOW : 3'b000;
        ew_nx = ns_nx;
      end
`endif
      default:   begin ns_nx = RED;    ew_nx = RED;    end
    endcase
  end

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Randomized scoreboard bench for traffic_light_ctrl (default build).
// A phase-table reference model predicts the outputs after each edge;
// a monitor compares them one time unit after every rising edge.
module tb_traffic_light_ctrl;

  localparam int G  = 8;
  localparam int Y  = 3;
  localparam int AR = 2;
  localparam int MG = 3;

  localparam logic [2:0] RED    = 3'b001;
  localparam logic [2:0] GREEN  = 3'b010;
  localparam logic [2:0] YELLOW = 3'b100;

  logic       clk = 1'b0;
  logic       rst, en, ped_req, flash;
  logic [2:0] light_ns, light_ew, phase;
  logic       ped_walk;

  traffic_light_ctrl #(
    .GREEN_CYCLES(G), .YELLOW_CYCLES(Y), .ALLRED_CYCLES(AR),
    .MIN_GREEN_CYCLES(MG), .FLASH_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .ped_req(ped_req), .flash(flash),
    .light_ns(light_ns), .light_ew(light_ew), .ped_walk(ped_walk), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] ns;
    logic [2:0] ew;
    logic [2:0] ph;
    logic       walk;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: the phase sequence as tables of dwell and lamp colour.
  int         dur[6]    = '{AR, G, Y, AR, G, Y};
  logic [2:0] ns_tab[6] = '{RED, GREEN, YELLOW, RED, RED, RED};
  logic [2:0] ew_tab[6] = '{RED, RED, RED, RED, GREEN, YELLOW};
  int p = 0;
  int e = 0;
  bit pend = 0;
  bit walk = 0;

  task automatic step(input bit r, input bit en_i, input bit pr, input bit fl);
    bit   np;
    bit   cut;
    exp_t x;
    @(negedge clk);
    rst = r; en = en_i; ped_req = pr; flash = fl;
    if (r) begin
      p = 0; e = 0; pend = 0; walk = 0;
    end else begin
      np  = pend | pr;
      cut = (p == 1 || p == 4) && pend && (e + 1 >= MG);
      if (en_i) begin
        if (e + 1 == dur[p] || cut) begin
          p = (p + 1) % 6;
          e = 0;
          if (p == 0 || p == 3) begin
            walk = pend;
            np   = pr;
          end else begin
            walk = 0;
          end
        end else begin
          e++;
        end
      end
      pend = np;
    end
    x.ns = ns_tab[p]; x.ew = ew_tab[p]; x.ph = 3'(p); x.walk = walk;
    q.push_back(x);
  endtask

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, req);
    end
  endtask

  // Monitor: every edge presents a new output set to compare.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        x = q.pop_front();
        chk("light_ns", light_ns, x.ns);
        chk("light_ew", light_ew, x.ew);
        chk("phase", phase, x.ph);
        chk("ped_walk", {2'b00, ped_walk}, {2'b00, x.walk});
      end
    end
  end

  // Stimulus: reset, clean free run, pedestrian pulses, then random mix.
  initial begin
    int budget;
    rst = 1'b1; en = 1'b0; ped_req = 1'b0; flash = 1'b0;
    repeat (2) step(1, 1, 0, 0);
    repeat (60) step(0, 1, 0, 1'($urandom_range(0, 1)));
    for (int k = 0; k < 26; k++) begin
      repeat (26 + k) step(0, 1, 0, 0);
      step(0, 1, 1, 0);
    end
    repeat (30) step(0, 1'($urandom_range(0, 1)), 0, 0);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 7) != 0,
           $urandom_range(0, 9) == 0, 1'($urandom_range(0, 1)));
    budget = 20;
    while (q.size() > 0 && budget > 0) begin
      @(posedge clk);
      #2;
      budget--;
    end
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
